// File: rtl/hex7seg_scan_driver_if.sv
// Load/display bundle between core logic and the
// seven-segment scan driver.
interface hex7seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output load, value_in, dp_in,
    output digit_en, lz_blank,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  load, value_in, dp_in,
    input  digit_en, lz_blank,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/hex7seg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with
// frame-atomic updates and leading-zero blanking.
module hex7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GHOST_BLANK    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic rst,
  hex7seg_scan_driver_if.slave bus
);
  localparam int TW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ND = NUM_DIGITS;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST =
    TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] BLANK_END =
    TW'(GHOST_BLANK);

  localparam logic [ND-1:0] AN_OFF =
    {ND{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0] SEG_OFF =
    {7{SEG_ACTIVE_LOW != 0}};
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_decode(
    input logic [3:0] nib
  );
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] pend_val_q, pend_val_d;
  logic [ND-1:0] pend_dp_q, pend_dp_d;
  logic [ND-1:0] pend_en_q, pend_en_d;
  logic [VW-1:0] act_val_q, act_val_d;
  logic [ND-1:0] act_dp_q, act_dp_d;
  logic [ND-1:0] act_en_q, act_en_d;
  logic [ND-1:0] an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic          run;
  logic          lit;
  logic [ND-1:0] supp;
  logic [3:0]    cur_nib;
  logic [ND-1:0] an_raw;
  logic [6:0]    seg_raw;
  logic          dp_raw;

  always_comb begin
    tick_d = tick_q + 1'b1;
    idx_d  = idx_q;
    wrap   = 1'b0;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
      pend_en_d  = bus.digit_en;
    end

    act_val_d = wrap ? pend_val_q : act_val_q;
    act_dp_d  = wrap ? pend_dp_q  : act_dp_q;
    act_en_d  = wrap ? pend_en_q  : act_en_q;

    // Suppression runs top-down; digit 0 always shows.
    run  = bus.lz_blank;
    supp = '0;
    for (int k = ND - 1; k >= 1; k--) begin
      run = run && (act_val_q[4*k +: 4] == 4'h0)
                && !act_dp_q[k];
      supp[k] = run;
    end

    cur_nib = act_val_q[4*idx_q +: 4];
    lit = (tick_q >= BLANK_END) && act_en_q[idx_q]
          && !supp[idx_q];

    an_raw  = lit ? (ND'(1) << idx_q) : '0;
    seg_raw = lit ? hex_decode(cur_nib) : '0;
    dp_raw  = lit && act_dp_q[idx_q];

    an_d  = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_raw : dp_raw;
    fd_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '1;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '1;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      fd_q       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: doc/hex7seg_scan_driver.md
Name: hex7seg_scan_driver

Overview:
- Multiplexed N-digit hexadecimal seven-segment display driver for board-level debug and status displays.
- Latches a packed nibble vector through a load strobe and decodes each nibble to segments internally.
- Scans the digit anodes at a programmable rate, with leading-zero suppression, per-digit enable, decimal points and anti-ghosting blanking.
- Sits between core logic and the board display pins. Frame-atomic updates keep a display from ever showing a torn value.

Parameters:
- NUM_DIGITS, 4: digit count (1..8).
- REFRESH_DIV, 50000: clk cycles per digit slot (must be > GHOST_BLANK).
- GHOST_BLANK, 1: cycles at the start of each slot with all anodes inactive (0..REFRESH_DIV-1).
- SEG_ACTIVE_LOW, 1: 1 means seg/dp are driven low = lit.
- AN_ACTIVE_LOW, 1: 1 means an is driven low = digit on.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures value_in/dp_in/digit_en into pending
- value_in  in  4*NUM_DIGITS  nibble k = digit k (digit 0 = least significant, rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit
- digit_en  in  NUM_DIGITS  1 = digit may light
- lz_blank  in  1  leading-zero suppression enable (live input, sampled each cycle)
- an  out  NUM_DIGITS  anode selects
- seg  out  7  seg[0]=a ... seg[6]=g
- dp  out  1  decimal point segment
- frame_done  out  1  one-cycle pulse per completed scan

Behaviour:
- Reset: one clk edge with rst=1 sets tick=0, idx=0, pending=0, active=0, digit_en copies=all-1, dp copies=0. It drives an=all inactive, seg=all off, dp=off, frame_done=0. Reset mid-scan aborts the slot immediately and discards any pending load.
- Tick counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 the counter wraps and idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame wrap is the edge on which idx goes from NUM_DIGITS-1 to 0. On that edge, active <= pending (value, dp, enables). frame_done is registered and is 1 in the cycle after the wrap edge. Its period is NUM_DIGITS*REFRESH_DIV cycles.
- load writes pending only; the last load before a wrap wins. A load coinciding with the wrap edge lands in pending and is displayed from the following frame. Active data never changes mid-frame.
- an, seg and dp are registered. In each cycle they reflect the tick, idx and active state of the previous cycle.
- Digit lit condition: tick >= GHOST_BLANK, digit_en[idx]=1, and the digit is not suppressed. Unlit means all anodes inactive, seg all off and dp off.
- Leading-zero suppression (lz_blank=1): scanning from digit NUM_DIGITS-1 downward, a digit is suppressed while its nibble=0 and its dp=0. Suppression stops at the first nonzero nibble or set dp. Digit 0 is never suppressed.
- Decode, as active-high gfedcba before polarity: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Polarity is applied last: SEG_ACTIVE_LOW inverts seg and dp; AN_ACTIVE_LOW inverts an. Exactly one anode is active when lit; none otherwise.
- Width rule: tick width is clog2(REFRESH_DIV) and idx width is clog2(NUM_DIGITS), minimum 1. No overflow past terminal counts.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GHOST_BLANK=1, both polarities active-low.
- Reset: rst=1 for 3 cycles -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0. After release, the first pulse of frame_done arrives 16 cycles later, then repeats every 16 cycles.
- Decode/scan: load value_in=16'h12AF, dp_in=0, digit_en=4'hF, lz_blank=0. From the first frame after the next wrap:
  - Digit 0 slot: an=4'b1110, seg=7'h0E (F).
  - Digit 1: an=4'b1101, seg=7'h08 (A).
  - Digit 2: an=4'b1011, seg=7'h24 (2).
  - Digit 3: an=4'b0111, seg=7'h79 (1).
  - In the first cycle of each slot, an=4'b1111.
- Sweep all 16 nibble values through digit 0 -> seg equals ~table entry each time.
- Leading-zero suppression, lz_blank=1:
  - value 16'h0050: digits 3 and 2 never light; digit 1 shows 7'h12; digit 0 shows 7'h40.
  - value 16'h0000: only digit 0 lights, with 7'h40.
  - value 16'h0000 with dp_in=4'b0100: digits 2..0 light; digit 2 has dp=0.
- Atomic update: load 16'h1111 mid-frame while 16'h2222 is active -> remaining slots of that frame still show 2. A load asserted exactly on the wrap edge shows one frame later.
- digit_en=4'b0101 -> digits 1 and 3 stay dark in their slots (an=4'b1111, seg=7'h7F).
- Reset during digit 2 slot -> next cycle outputs are fully off. Scan resumes at digit 0 and displays 0 until a new load.
